// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - ID-stage decode with multi-cycle MUL sequencer; optional perf counters via CTRL_PERF_CNT_EN
module control_unit_mc #(
   parameter int MUL_LATENCY = 2,
   parameter int CNT_W       = 4,
   parameter int ALU_OP_W    = 2
) (
   input  logic                clk,
   input  logic                arst,
   input  logic [6:0]          opcode,
   input  logic [6:0]          funct7,
   input  logic                id_valid,
   input  logic                flush,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src,
   output logic                mem_read,
   output logic                mem_write,
   output logic                mem_2_reg,
   output logic                reg_write,
   output logic                branch,
   output logic                jump,
   output logic                mul_start,
   output logic                stall,
   output logic                mul_busy,
   output logic                illegal,
   output logic                illegal_seen
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]         mul_count,
   output logic [31:0]         stall_count
`endif
);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_BR     = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LD     = 7'b0000011;
   localparam logic [6:0] OPC_ST     = 7'b0100011;
   localparam logic [6:0] F7_ADD     = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;
   localparam logic [6:0] F7_MUL     = 7'b0000001;

   localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] OP_R   = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] OP_MUL = ALU_OP_W'(3);

   // The first ID cycle of a MUL is spent in IDLE, so RUN counts the remaining cycles minus one
   localparam int                LOAD_I   = (MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LOAD_I);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;

   logic [ALU_OP_W-1:0]  dec_alu_op;
   logic                 dec_alu_src, dec_mem_read, dec_mem_write, dec_mem_2_reg;
   logic                 dec_reg_write, dec_branch, dec_jump;
   logic                 dec_legal, dec_mul;
   logic                 emit_dec, emit_mul;

   // Raw opcode/funct7 decode, independent of FSM state and bubbles
   always_comb begin
      dec_alu_op    = OP_ADD;
      dec_alu_src   = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_mem_2_reg = 1'b0;
      dec_reg_write = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
      dec_legal     = 1'b1;
      dec_mul       = 1'b0;
      case (opcode)
         OPC_R: begin
            if (funct7 == F7_ADD || funct7 == F7_SUB) begin
               dec_reg_write = 1'b1;
               dec_alu_op    = OP_R;
            end else if (funct7 == F7_MUL) begin
               dec_mul       = 1'b1;
               dec_reg_write = 1'b1;
               dec_alu_op    = OP_MUL;
            end else begin
               dec_legal = 1'b0;
            end
         end
         OPC_I: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
         end
         OPC_BR: begin
            dec_branch = 1'b1;
            dec_alu_op = OP_SUB;
         end
         OPC_JAL: begin
            dec_jump = 1'b1;
         end
         OPC_LD: begin
            dec_alu_src   = 1'b1;
            dec_mem_read  = 1'b1;
            dec_mem_2_reg = 1'b1;
            dec_reg_write = 1'b1;
         end
         OPC_ST: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // MUL sequencer next-state and the final gating of control outputs into bubbles
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mul_start  = 1'b0;
      stall      = 1'b0;
      mul_busy   = 1'b0;
      emit_dec   = 1'b0;
      emit_mul   = 1'b0;
      // The held MUL in RUN is known legal, so encodings are only judged in IDLE
      illegal    = (state == S_IDLE) && id_valid && !dec_legal;

      case (state)
         S_IDLE: begin
            if (id_valid && !flush && dec_mul) begin
               mul_start = 1'b1;
               if (MUL_LATENCY == 1) begin
                  emit_mul = 1'b1;
               end else begin
                  stall      = 1'b1;
                  cnt_next   = CNT_LOAD;
                  state_next = S_RUN;
               end
            end else if (id_valid && !flush && dec_legal) begin
               emit_dec = 1'b1;
            end
         end
         S_RUN: begin
            mul_busy = 1'b1;
            if (flush) begin
               // Flush wins over completion: the MUL is dropped without issuing
               cnt_next   = '0;
               state_next = S_IDLE;
            end else if (cnt != '0) begin
               stall    = 1'b1;
               cnt_next = cnt - CNT_W'(1);
            end else begin
               emit_mul   = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      alu_op    = OP_ADD;
      alu_src   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_2_reg = 1'b0;
      reg_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      if (emit_dec) begin
         alu_op    = dec_alu_op;
         alu_src   = dec_alu_src;
         mem_read  = dec_mem_read;
         mem_write = dec_mem_write;
         mem_2_reg = dec_mem_2_reg;
         reg_write = dec_reg_write;
         branch    = dec_branch;
         jump      = dec_jump;
      end else if (emit_mul) begin
         alu_op    = OP_MUL;
         reg_write = 1'b1;
      end
   end

   // State, latency counter and sticky illegal flag
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         illegal_seen <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         illegal_seen <= illegal_seen | illegal;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   // Free-running event counters, wrapping at 2^32
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         mul_count   <= '0;
         stall_count <= '0;
      end else begin
         mul_count   <= mul_count + 32'(mul_start);
         stall_count <= stall_count + 32'(stall);
      end
   end
`endif

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Decode unit for the pipelined RISC-V core, placed in the ID stage. Generates datapath control signals.
- Separates MUL from the other R-type instructions using funct7.
- Sequences a multi-cycle multiplier: holds the MUL instruction in ID for MUL_LATENCY cycles and stalls IF/ID/PC. Issues the MUL into EX exactly once, on its final ID cycle.
- Flags illegal encodings with a sticky status bit.

Parameters:
- MUL_LATENCY, 2, multiplier latency in cycles; legal range 1..2^CNT_W.
- CNT_W, 4, width of the latency down-counter.
- ALU_OP_W, 2, width of alu_op; must be >= 2.

Ports:
- clk  in  1  core clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- opcode  in  7  instruction[6:0] from IF/ID.
- funct7  in  7  instruction[31:25] from IF/ID.
- id_valid  in  1  IF/ID holds a valid instruction.
- flush  in  1  taken branch/jump; kill the ID instruction.
- alu_op  out  ALU_OP_W  00 ADD, 01 SUB, 10 R-type, 11 MUL.
- alu_src  out  1  ALU operand B is the immediate.
- mem_read  out  1  load.
- mem_write  out  1  store.
- mem_2_reg  out  1  writeback data comes from memory.
- reg_write  out  1  register-file write.
- branch  out  1  beq.
- jump  out  1  jal.
- mul_start  out  1  one-cycle pulse that launches the multiplier.
- stall  out  1  hold PC and IF/ID.
- mul_busy  out  1  FSM is in the RUN state.
- illegal  out  1  combinational; current valid instruction is illegal.
- illegal_seen  out  1  sticky; set by any illegal instruction, cleared only by arst.

Behaviour:
- Decode (combinational), selected by opcode:
  - 0110011 with funct7 0000000 or 0100000: R-type; reg_write=1, alu_op=10.
  - 0110011 with funct7 0000001: MUL; reg_write=1, alu_op=11.
  - 0010011: ALU-I; alu_src=1, reg_write=1, alu_op=00.
  - 1100011: branch=1, alu_op=01.
  - 1101111: jump=1, alu_op=00.
  - 0000011: alu_src=1, mem_read=1, mem_2_reg=1, reg_write=1, alu_op=00.
  - 0100011: alu_src=1, mem_write=1, alu_op=00.
  - Any other opcode, or 0110011 with any other funct7: illegal=1 (only when id_valid=1).
- Bubble: all control outputs 0 (alu_op=00). A bubble is emitted when any of these holds:
  - id_valid=0, flush=1, illegal=1, or stall=1.
- FSM states: IDLE and RUN. The counter cnt is CNT_W bits wide.
- IDLE, valid MUL, flush=0:
  - mul_start=1.
  - If MUL_LATENCY=1: emit the MUL controls this cycle, stall=0, remain in IDLE.
  - Else: stall=1, emit a bubble, load cnt=MUL_LATENCY-2, go to RUN.
- RUN:
  - mul_busy=1 and mul_start=0.
  - While cnt!=0: stall=1, emit a bubble, decrement cnt.
  - When cnt=0: stall=0, emit the MUL controls, go to IDLE.
  - The MUL therefore occupies ID for exactly MUL_LATENCY cycles.
- flush in RUN: go to IDLE next cycle.
  - In that cycle: stall=0, bubble, no MUL controls issued, cnt cleared.
  - Flush has priority over counter completion.
- Non-MUL instructions in IDLE decode in a single cycle with stall=0.
- opcode and funct7 are ignored in RUN, except that flush is still honoured.
- illegal_seen is set on the clock edge after any cycle with illegal=1.
- Reset (async, immediate): state=IDLE, cnt=0, illegal_seen=0.
  - Outputs then follow the combinational decode, giving stall=0 and mul_busy=0.
  - Reset asserted mid-MUL aborts the sequence; no MUL controls are emitted.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, two ports are added:
  - mul_count  out  32: increments on each mul_start pulse.
  - stall_count  out  32: increments on each cycle with stall=1.
  - Both reset to 0 on arst and wrap modulo 2^32.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- ADD (opcode 0110011, funct7 0000000, id_valid=1) -> same cycle: alu_op=10, reg_write=1, stall=0, mul_start=0.
- MUL (funct7 0000001) with MUL_LATENCY=3 ->
  - cycle 0: mul_start=1, stall=1, bubble.
  - cycle 1: stall=1, mul_busy=1.
  - cycle 2: stall=0, alu_op=11, reg_write=1.
  - cycle 3: FSM back in IDLE.
- MUL with MUL_LATENCY=1 -> single cycle: mul_start=1, stall=0, alu_op=11; mul_busy stays 0.
- MUL_LATENCY=4, flush=1 in the 2nd RUN cycle -> next cycle: IDLE, stall=0, all controls 0; the MUL controls are never issued.
- Illegal opcode 1111111 with id_valid=1 -> illegal=1 and a bubble that cycle; illegal_seen=1 from the next cycle on; cleared only by arst.
- arst pulse during RUN (MUL_LATENCY=4) -> immediately: mul_busy=0, stall=0, illegal_seen=0; with CTRL_PERF_CNT_EN defined, mul_count=0 and stall_count=0.
